// File: rtl/rxll_pkg.sv
// Shared definitions for the receive link-layer FIS scheduler: FIS type codes,
// scheduler states and error codes.
package rxll_pkg;

    localparam logic [7:0] FIS_TYPE_REG_D2H   = 8'h34;
    localparam logic [7:0] FIS_TYPE_DMA_SETUP = 8'h41;
    localparam logic [7:0] FIS_TYPE_PIO_SETUP = 8'h5F;
    localparam logic [7:0] FIS_TYPE_SDB       = 8'hA1;
    localparam logic [7:0] FIS_TYPE_DMA_ACT   = 8'h39;
    localparam logic [7:0] FIS_TYPE_BIST      = 8'h58;
    localparam logic [7:0] FIS_TYPE_DATA      = 8'h46;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_REG,
        ST_DROP,
        ST_DONE
    } rxll_state_e;

    typedef enum logic [1:0] {
        ERR_NO_SOF   = 2'd0,
        ERR_UNKNOWN  = 2'd1,
        ERR_OVERSIZE = 2'd2,
        ERR_TRUNC    = 2'd3
    } rxll_err_e;

    // Register-class FIS are the ones that land in the shadow buffer.
    function automatic logic is_reg_fis(input logic [7:0] fis_type);
        return (fis_type == FIS_TYPE_REG_D2H)   ||
               (fis_type == FIS_TYPE_DMA_SETUP) ||
               (fis_type == FIS_TYPE_PIO_SETUP) ||
               (fis_type == FIS_TYPE_SDB)       ||
               (fis_type == FIS_TYPE_DMA_ACT)   ||
               (fis_type == FIS_TYPE_BIST);
    endfunction

    function automatic logic [7:0] hdr_type(input logic [31:0] hdr_dword);
        return hdr_dword[7:0];
    endfunction

endpackage

// File: rtl/rxll_fis_hdr_dec.sv
// Combinational classification of a FIS header type byte; shared by the RX
// scheduler and the TX path.
module rxll_fis_hdr_dec
    import rxll_pkg::*;
#(
    parameter logic [7:0] C_DATA_TYPE = FIS_TYPE_DATA
) (
    input  logic [7:0] hdr_type_i,
    output logic       is_data_o,
    output logic       is_reg_o,
    output logic       is_unknown_o
);

    // The data code wins if it ever collides with a register-class code.
    always_comb begin
        is_data_o    = (hdr_type_i == C_DATA_TYPE);
        is_reg_o     = !is_data_o && is_reg_fis(hdr_type_i);
        is_unknown_o = !is_data_o && !is_reg_o;
    end

endmodule

// File: rtl/rxll_fis_sched.sv
// Drains the RX link-layer FIFO one frame at a time, routing data FIS to the
// DMA write stream and register FIS into the shadow buffer.
module rxll_fis_sched
    import rxll_pkg::*;
#(
    parameter int unsigned C_MAX_REG_DW = 7,
    parameter logic [7:0]  C_DATA_TYPE  = 8'h46
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        ctrl_en,
    input  logic [31:0] rxfifo_data,
    input  logic        rxfifo_sof,
    input  logic        rxfifo_eof,
    input  logic        rxfifo_empty,
    input  logic        rxfifo_eof_rdy,
    output logic        rxfifo_rd_en,
    output logic [31:0] dma_wdata,
    output logic        dma_wvalid,
    output logic        dma_wlast,
    input  logic        dma_wready,
    output logic        fis_wr_en,
    output logic [2:0]  fis_waddr,
    output logic [31:0] fis_wdata,
    output logic        fis_done,
    output logic [7:0]  fis_type,
    output logic        fis_err,
    output logic [1:0]  fis_err_code
);

    localparam logic [2:0] LAST_IDX = 3'(C_MAX_REG_DW - 1);

    rxll_state_e state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  type_q, type_d;
    logic [7:0]  fis_type_q, fis_type_d;
    rxll_err_e   err_code_q, err_code_d;
    logic        reg_ok_q, reg_ok_d;
    logic        err_pulse;
    logic        hdr_is_data;
    logic        hdr_is_reg;
    logic        hdr_is_unknown;
    logic        start_ok;

    rxll_fis_hdr_dec #(
        .C_DATA_TYPE (C_DATA_TYPE)
    ) u_hdr_dec (
        .hdr_type_i   (hdr_type(rxfifo_data)),
        .is_data_o    (hdr_is_data),
        .is_reg_o     (hdr_is_reg),
        .is_unknown_o (hdr_is_unknown)
    );

    // Reset also masks the IDLE decision so no pop or error escapes while held.
    assign start_ok = ctrl_en && !rxfifo_empty && sys_rst_n;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            type_q     <= '0;
            fis_type_q <= '0;
            err_code_q <= ERR_NO_SOF;
            reg_ok_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            type_q     <= type_d;
            fis_type_q <= fis_type_d;
            err_code_q <= err_code_d;
            reg_ok_q   <= reg_ok_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        type_d       = type_q;
        fis_type_d   = fis_type_q;
        err_code_d   = err_code_q;
        reg_ok_d     = reg_ok_q;
        err_pulse    = 1'b0;
        rxfifo_rd_en = 1'b0;
        dma_wvalid   = 1'b0;
        dma_wdata    = '0;
        dma_wlast    = 1'b0;
        fis_wr_en    = 1'b0;
        fis_waddr    = '0;
        fis_wdata    = '0;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    if (!rxfifo_sof) begin
                        err_pulse  = 1'b1;
                        err_code_d = ERR_NO_SOF;
                        state_d    = ST_DROP;
                    end else if (hdr_is_data) begin
                        rxfifo_rd_en = 1'b1;
                        type_d       = hdr_type(rxfifo_data);
                        reg_ok_d     = 1'b0;
                        if (rxfifo_eof) begin
                            err_pulse  = 1'b1;
                            err_code_d = ERR_TRUNC;
                            state_d    = ST_DONE;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else if (hdr_is_reg) begin
                        // Header stays in the FIFO; REG pops it as shadow dword 0.
                        if (rxfifo_eof_rdy) begin
                            type_d   = hdr_type(rxfifo_data);
                            reg_ok_d = 1'b1;
                            idx_d    = '0;
                            state_d  = ST_REG;
                        end
                    end else if (hdr_is_unknown) begin
                        err_pulse  = 1'b1;
                        err_code_d = ERR_UNKNOWN;
                        state_d    = ST_DROP;
                    end
                end
            end

            ST_DATA: begin
                if (!rxfifo_empty) begin
                    if (rxfifo_sof) begin
                        err_pulse  = 1'b1;
                        err_code_d = ERR_TRUNC;
                        state_d    = ST_IDLE;
                    end else begin
                        dma_wvalid = 1'b1;
                        dma_wdata  = rxfifo_data;
                        dma_wlast  = rxfifo_eof;
                        if (dma_wready) begin
                            rxfifo_rd_en = 1'b1;
                            if (rxfifo_eof) begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                end
            end

            ST_REG: begin
                if (!rxfifo_empty) begin
                    rxfifo_rd_en = 1'b1;
                    fis_wr_en    = 1'b1;
                    fis_waddr    = idx_q;
                    fis_wdata    = rxfifo_data;
                    idx_d        = idx_q + 3'd1;
                    if (rxfifo_eof) begin
                        state_d = ST_DONE;
                    end else if (idx_q == LAST_IDX) begin
                        err_pulse  = 1'b1;
                        err_code_d = ERR_OVERSIZE;
                        reg_ok_d   = 1'b0;
                        state_d    = ST_DROP;
                    end
                end
            end

            ST_DROP: begin
                if (!rxfifo_empty) begin
                    rxfifo_rd_en = 1'b1;
                    if (rxfifo_eof) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_DONE: begin
                fis_type_d = type_q;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign fis_done     = (state_q == ST_DONE) && reg_ok_q;
    assign fis_type     = fis_type_q;
    assign fis_err      = err_pulse;
    assign fis_err_code = err_code_d;

endmodule

// File: doc/rxll_fis_sched.md
Name: rxll_fis_sched

Overview:
- Drains the receive link-layer FIFO (read side, sys_clk domain) one frame at a time.
- Decodes the FIS type from the header dword and routes the frame to one of two sinks:
  - Data FIS payload goes to the DMA write stream with a valid/ready handshake.
  - Register-class FIS go into the 8-dword FIS shadow buffer, followed by a completion pulse.
- Malformed, unknown and oversize frames are flushed to EOF and reported.

Parameters:
- C_MAX_REG_DW, 7: maximum dwords of a register-class FIS, header included. Range 1..8.
- C_DATA_TYPE, 8'h46: FIS type code routed to DMA.

Ports:
- sys_clk  in  1  block clock; all logic on rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- ctrl_en  in  1  1 = may start new frames; 0 = current frame completes, then block holds in IDLE
- rxfifo_data  in  32  FIFO head dword (first-word-fall-through)
- rxfifo_sof  in  1  head dword is the first dword of a frame
- rxfifo_eof  in  1  head dword is the last dword of a frame
- rxfifo_empty  in  1  FIFO head not valid
- rxfifo_eof_rdy  in  1  at least one complete frame (EOF) is in the FIFO
- rxfifo_rd_en  out  1  pop head dword this cycle
- dma_wdata  out  32  payload dword
- dma_wvalid  out  1  payload valid
- dma_wlast  out  1  last payload dword of the frame
- dma_wready  in  1  DMA accepts the dword
- fis_wr_en  out  1  shadow buffer write strobe
- fis_waddr  out  3  shadow dword index
- fis_wdata  out  32  shadow write data
- fis_done  out  1  one-cycle pulse: register FIS completely written
- fis_type  out  8  type of the last completed frame
- fis_err  out  1  one-cycle pulse: error detected
- fis_err_code  out  2  0 = no SOF, 1 = unknown type, 2 = oversize, 3 = truncated or empty

Behaviour:
- Reset values: all outputs 0; state IDLE.
- FIFO rule: a pop occurs only when rxfifo_rd_en=1 and rxfifo_empty=0. rxfifo_rd_en is never asserted while the FIFO is empty.
- Register-class type codes: 34h, 41h, 5Fh, A1h, 39h, 58h. Any other code except C_DATA_TYPE is unknown.

States:
- IDLE: waits for ctrl_en & !empty.
  - Head with sof=0 → DROP, err code 0.
  - Head type = C_DATA_TYPE → pop header, latch type, go to DATA. If eof=1 on the header → err code 3, go to DONE.
  - Head type is register-class and rxfifo_eof_rdy=1 → go to REG. The header is not popped in IDLE. The whole frame is present before any shadow write, so shadow updates are atomic.
  - Head type unknown → err code 1, go to DROP.
- DATA:
  - dma_wvalid = !empty & !sof; dma_wdata = rxfifo_data; dma_wlast = rxfifo_eof.
  - Pop when dma_wvalid & dma_wready.
  - When dma_wready=0, the head dword stays on dma_wdata and the FIFO is not popped.
  - Popping a dword with eof → DONE.
  - Head with sof=1 (previous frame lost its EOF) → err code 3, no pop, return to IDLE.
- REG: pops one dword per cycle.
  - Each pop writes fis_wr_en=1, fis_waddr=idx, fis_wdata=head, combinationally in the pop cycle. idx starts at 0.
  - Popping a dword with eof → DONE with the fis_done pulse.
  - idx reaching C_MAX_REG_DW without eof → err code 2, go to DROP. Dwords already written stay in the shadow buffer; fis_done is not asserted.
- DROP: pops every available dword until the eof dword is popped, then returns to IDLE. No sink outputs are driven.
- DONE: one cycle.
  - fis_type updates here.
  - fis_done=1 only if the frame was register-class and error-free.
  - Returns to IDLE. No pop occurs in DONE, giving 1 bubble cycle per frame.

Latency and rates:
- Register FIS: from IDLE with eof_rdy=1 to fis_done = N+2 cycles for N dwords.
- DATA sustains 1 dword/cycle when dma_wready=1.

Timing of fis_err: pulses in the cycle the error is decided; fis_err_code holds until the next error.

ctrl_en:
- Only gates the IDLE exit.
- Deasserting it mid-frame has no effect until the frame reaches DONE or DROP exit.

Reset:
- Reset mid-frame returns to IDLE immediately and clears every output.
- The remnant of the partial frame is later flushed by the "no SOF" DROP path.

Decomposition:
- Shared package rxll_pkg:
  - FIS type constants and the register-class membership function.
  - State encoding (IDLE, DATA, REG, DROP, DONE).
  - Error code constants.
- One natural sub-module, rxll_fis_hdr_dec: combinational decode of the header dword into {is_data, is_reg, is_unknown}. It is reused by the TX path.

Test Plan:
- D2H register FIS, 5 dwords (34h…), eof_rdy=1, ctrl_en=1 → fis_waddr 0..4 written on consecutive cycles, fis_done at cycle 7, fis_type=34h.
- Data FIS, header plus 4 payload dwords, dma_wready toggled 1,0,1,1,0,1 → exactly 4 beats, data order preserved, dma_wlast on the 4th, no pop while ready=0.
- Register FIS of 9 dwords with C_MAX_REG_DW=7 → 7 shadow writes, fis_err with code 2, remaining 2 dwords dropped, next frame processed normally.
- Head type 27h (unknown) with 3 dwords → fis_err with code 1, 3 pops, no sink activity; head with sof=0 → fis_err with code 0 and flush to EOF.
- Data FIS missing EOF, followed by a new SOF (34h frame) → fis_err with code 3, return to IDLE, register FIS then completes with fis_done.
- sys_rst_n asserted in the middle of a register FIS, then released → all outputs 0; leftover dwords flushed with code 0; ctrl_en=0 leaves the FIFO untouched.
